fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port run, input, 1 bit: fetch enable.
REQ-004 SHALL have port address, output, 4 bits: program ROM address, equal to the pc register.
REQ-005 SHALL have port instruction, input, 16 bits: ROM word at address, combinational, same cycle.
REQ-006 SHALL have port ir, output, 16 bits: issued instruction.
REQ-007 SHALL have port ir_pc, output, 4 bits: address ir was fetched from.
REQ-008 SHALL have port ir_valid, output, 1 bit: ir holds an unconsumed instruction.
REQ-009 SHALL have port ir_ready, input, 1 bit: downstream accepts ir this cycle when ir_valid=1.
REQ-010 SHALL have port redirect_valid, input, 1 bit: downstream pc redirect and flush.
REQ-011 SHALL have port redirect_addr, input, 4 bits: redirect target.
REQ-012 SHALL have port issue_count, output, 8 bits: instructions issued count.
REQ-013 SHALL have port state, output, 2 bits: IDLE=00, FETCH=01, STALL=10.

Function
REQ-014 Decode SHALL use opcode instruction[15:12]; JMP=4'b1100, target instruction[3:0]; all other opcodes SHALL be issued unmodified.
REQ-015 Slot free SHALL mean ir_valid=0 or ir_ready=1; fetch fires when state!=IDLE, run=1, slot free, redirect_valid=0.
REQ-016 Fire with non-JMP SHALL set: ir<=instruction, ir_pc<=pc, ir_valid<=1, pc<=pc+1 mod 16 (15 wraps to 0), issue_count<=issue_count+1 mod 256.
REQ-017 Fire with JMP SHALL set pc<=instruction[3:0], ir_valid<=0; JMP is never issued and issue_count is unchanged (one-cycle bubble).
REQ-018 JMP targeting its own address SHALL loop forever with ir_valid=0; no error detection.
REQ-019 ir_valid=1 and ir_ready=0 SHALL hold ir, ir_pc, ir_valid, pc and issue_count.
REQ-020 No fire with slot free SHALL give ir_valid<=0; pc holds.
REQ-021 redirect_valid=1 SHALL take priority over all else: pc<=redirect_addr, ir_valid<=0, no fetch that cycle, issue_count unchanged; ir/ir_pc hold their values.
REQ-022 redirect_valid=1 in IDLE SHALL still load pc.
REQ-023 IDLE->FETCH SHALL occur when run=1; first fire is in the following cycle.
REQ-024 FETCH->STALL SHALL occur when ir_valid=1 and ir_ready=0 at the clock edge; STALL->FETCH when ir_ready=1.
REQ-025 FETCH or STALL SHALL go to IDLE when run=0 and (ir_valid=0 or ir_ready=1); a pending ir SHALL be held until accepted and then drop.
REQ-026 address SHALL equal pc at all times, combinationally.

Reset
REQ-027 rst_n=0 at a clock edge SHALL set pc=0, ir=16'h0000, ir_pc=0, ir_valid=0, issue_count=0, state=IDLE, overriding run, redirect and handshake inputs.
REQ-028 Reset mid-operation SHALL discard pending ir; after release, the first fetch is from address 0.

Verification
REQ-029 Test: ROM {0:16'h1202, 1:16'h2240, 2:16'hF200, 3:16'hC000}, run=1, ir_ready=1 from reset release.
- Expect ir 1202@0, 2240@1, F200@2 on consecutive cycles.
- Then one cycle ir_valid=0.
- Then 1202@0 again; issue_count=3 before the repeat.
REQ-030 Test: hold ir_ready=0 for 3 cycles while ir=16'h2240.
- Expect state=STALL, ir/ir_pc=1 stable, address=2.
- On ir_ready=1, next ir=16'hF200.
REQ-031 Test: redirect_valid=1, redirect_addr=9 while ir_valid=1.
- Next cycle expect ir_valid=0, address=9.
- Following cycle expect ir_pc=9.
REQ-032 Test: pc=15 holding non-JMP, run=1.
- Expect ir_pc=15, then address=0.
- issue_count wraps 255->0 after 256 issues.
REQ-033 Test: run=0 while ir_valid=1, ir_ready=0.
- Expect ir held; state stays STALL.
- After ir_ready=1, expect ir_valid=0, state=IDLE, pc unchanged.
REQ-034 Test: rst_n=0 for one cycle mid-stream.
- Expect all REQ-027 values next cycle.
- With run=1 held, expect 16'h1202@0 two cycles after release.

Source files
------------

// File: rtl/fetch_unit.sv
// Single-issue instruction fetch stage: reads a 16-entry program ROM, folds JMPs
// into the pc, and presents each other instruction on a valid/ready output register.
module fetch_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   output logic [3:0]  address,
   input  logic [15:0] instruction,
   output logic [15:0] ir,
   output logic [3:0]  ir_pc,
   output logic        ir_valid,
   input  logic        ir_ready,
   input  logic        redirect_valid,
   input  logic [3:0]  redirect_addr,
   output logic [7:0]  issue_count,
   output logic [1:0]  state
);

   // Handshake: ir/ir_pc transfer on a rising edge where ir_valid=1 and
   // ir_ready=1; while ir_valid=1 and ir_ready=0 the payload is frozen.
   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_FETCH = 2'b01,
      S_STALL = 2'b10
   } state_t;

   localparam logic [3:0] OP_JMP = 4'b1100;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_pc;
   logic [3:0]  w_pc_nxt;
   logic [15:0] r_ir;
   logic [15:0] w_ir_nxt;
   logic [3:0]  r_ir_pc;
   logic [3:0]  w_ir_pc_nxt;
   logic        r_ir_valid;
   logic        w_ir_valid_nxt;
   logic [7:0]  r_issue_count;
   logic [7:0]  w_issue_count_nxt;

   logic        w_slot_free;
   logic        w_fire;
   logic        w_is_jmp;

   assign w_slot_free = !r_ir_valid || ir_ready;
   assign w_fire      = (r_state != S_IDLE) && run && w_slot_free && !redirect_valid;
   assign w_is_jmp    = (instruction[15:12] == OP_JMP);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; a held ir must drain before stopping
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (run) begin
               w_state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            if (!run && w_slot_free) begin
               w_state_nxt = S_IDLE;
            end else if (r_ir_valid && !ir_ready) begin
               w_state_nxt = S_STALL;
            end
         end
         S_STALL: begin
            if (!run && w_slot_free) begin
               w_state_nxt = S_IDLE;
            end else if (ir_ready) begin
               w_state_nxt = S_FETCH;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath next values; redirect outranks any fetch in the same cycle
   always_comb begin
      w_pc_nxt          = r_pc;
      w_ir_nxt          = r_ir;
      w_ir_pc_nxt       = r_ir_pc;
      w_ir_valid_nxt    = r_ir_valid;
      w_issue_count_nxt = r_issue_count;
      if (redirect_valid) begin
         w_pc_nxt       = redirect_addr;
         w_ir_valid_nxt = 1'b0;
      end else if (w_fire) begin
         if (w_is_jmp) begin
            w_pc_nxt       = instruction[3:0];
            w_ir_valid_nxt = 1'b0;
         end else begin
            w_ir_nxt          = instruction;
            w_ir_pc_nxt       = r_pc;
            w_ir_valid_nxt    = 1'b1;
            w_pc_nxt          = r_pc + 4'd1;
            w_issue_count_nxt = r_issue_count + 8'd1;
         end
      end else if (w_slot_free) begin
         w_ir_valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc          <= 4'd0;
         r_ir          <= 16'h0000;
         r_ir_pc       <= 4'd0;
         r_ir_valid    <= 1'b0;
         r_issue_count <= 8'd0;
      end else begin
         r_pc          <= w_pc_nxt;
         r_ir          <= w_ir_nxt;
         r_ir_pc       <= w_ir_pc_nxt;
         r_ir_valid    <= w_ir_valid_nxt;
         r_issue_count <= w_issue_count_nxt;
      end
   end

   assign address     = r_pc;
   assign ir          = r_ir;
   assign ir_pc       = r_ir_pc;
   assign ir_valid    = r_ir_valid;
   assign issue_count = r_issue_count;
   assign state       = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized run/ready/redirect/reset
// traffic, all outputs compared every cycle against a behavioural model.
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic [3:0]  address;
   logic [15:0] instruction;
   logic [15:0] ir;
   logic [3:0]  ir_pc;
   logic        ir_valid;
   logic        ir_ready;
   logic        redirect_valid;
   logic [3:0]  redirect_addr;
   logic [7:0]  issue_count;
   logic [1:0]  state;

   logic [15:0] rom [16];

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_FETCH = 2'b01;
   localparam logic [1:0] ST_STALL = 2'b10;

   // Reference model state
   logic [3:0]  m_pc;
   logic [15:0] m_ir;
   logic [3:0]  m_ir_pc;
   logic        m_valid;
   logic [7:0]  m_cnt;
   logic [1:0]  m_state;

   fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .run            (run),
      .address        (address),
      .instruction    (instruction),
      .ir             (ir),
      .ir_pc          (ir_pc),
      .ir_valid       (ir_valid),
      .ir_ready       (ir_ready),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .issue_count    (issue_count),
      .state          (state)
   );

   assign instruction = rom[address];

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock of the architectural rules, from the inputs presented this cycle
   task automatic model_step();
      logic        free;
      logic        fire;
      logic [15:0] word;
      logic [1:0]  ns;
      if (!rst_n) begin
         m_pc = 4'd0; m_ir = 16'h0000; m_ir_pc = 4'd0;
         m_valid = 1'b0; m_cnt = 8'd0; m_state = ST_IDLE;
         return;
      end
      free = !m_valid || ir_ready;
      fire = (m_state != ST_IDLE) && run && free && !redirect_valid;
      word = rom[m_pc];
      if (m_state == ST_IDLE)                            ns = run ? ST_FETCH : ST_IDLE;
      else if (!run && free)                             ns = ST_IDLE;
      else if (m_state == ST_FETCH && m_valid && !ir_ready) ns = ST_STALL;
      else if (m_state == ST_STALL && ir_ready)          ns = ST_FETCH;
      else                                               ns = m_state;
      if (redirect_valid) begin
         m_pc = redirect_addr;
         m_valid = 1'b0;
      end else if (fire) begin
         if (word[15:12] == 4'hC) begin
            m_pc = word[3:0];
            m_valid = 1'b0;
         end else begin
            m_ir    = word;
            m_ir_pc = m_pc;
            m_valid = 1'b1;
            m_pc    = 4'((int'(m_pc) + 1) % 16);
            m_cnt   = 8'((int'(m_cnt) + 1) % 256);
         end
      end else if (free) begin
         m_valid = 1'b0;
      end
      m_state = ns;
   endtask

   // Driver: advance one clock and compare every output to the model
   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      check_eq("address",     16'(address),     16'(m_pc));
      check_eq("ir",          ir,               m_ir);
      check_eq("ir_pc",       16'(ir_pc),       16'(m_ir_pc));
      check_eq("ir_valid",    16'(ir_valid),    16'(m_valid));
      check_eq("issue_count", 16'(issue_count), 16'(m_cnt));
      check_eq("state",       16'(state),       16'(m_state));
   endtask

   task automatic load_base_rom();
      for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
      rom[0] = 16'h1202;
      rom[1] = 16'h2240;
      rom[2] = 16'hF200;
      rom[3] = 16'hC000;
   endtask

   task automatic randomize_rom();
      logic [15:0] w;
      for (int i = 0; i < 16; i++) begin
         w = 16'($urandom);
         if ($urandom_range(0, 3) == 0) w[15:12] = 4'hC;
         else if (w[15:12] == 4'hC) w[15:12] = 4'h3;
         rom[i] = w;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; run = 1'b0; ir_ready = 1'b0;
      redirect_valid = 1'b0; redirect_addr = 4'd0;
      load_base_rom();
      do_reset();
      check_eq("rst_state", 16'(state), 16'(ST_IDLE));
      check_eq("rst_valid", 16'(ir_valid), 16'h0);

      // Basic stream with JMP back to 0
      run = 1'b1; ir_ready = 1'b1;
      step();
      check_eq("t1_fetch_state", 16'(state), 16'(ST_FETCH));
      step();
      check_eq("t1_ir0", ir, 16'h1202); check_eq("t1_pc0", 16'(ir_pc), 16'd0);
      step();
      check_eq("t1_ir1", ir, 16'h2240); check_eq("t1_pc1", 16'(ir_pc), 16'd1);
      step();
      check_eq("t1_ir2", ir, 16'hF200); check_eq("t1_pc2", 16'(ir_pc), 16'd2);
      check_eq("t1_cnt3", 16'(issue_count), 16'd3);
      step();
      check_eq("t1_bubble", 16'(ir_valid), 16'h0);
      check_eq("t1_cnt_jmp", 16'(issue_count), 16'd3);
      step();
      check_eq("t1_ir_rep", ir, 16'h1202); check_eq("t1_pc_rep", 16'(ir_pc), 16'd0);

      // Stall while ir=2240
      step();
      check_eq("t2_ir", ir, 16'h2240);
      ir_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("t2_state", 16'(state), 16'(ST_STALL));
         check_eq("t2_ir_hold", ir, 16'h2240);
         check_eq("t2_pc_hold", 16'(ir_pc), 16'd1);
         check_eq("t2_addr", 16'(address), 16'd2);
      end
      ir_ready = 1'b1;
      step();
      check_eq("t2_next_ir", ir, 16'hF200);

      // Redirect while ir_valid=1
      redirect_valid = 1'b1; redirect_addr = 4'd9;
      step();
      check_eq("t3_valid", 16'(ir_valid), 16'h0);
      check_eq("t3_addr", 16'(address), 16'd9);
      redirect_valid = 1'b0;
      step();
      check_eq("t3_ir_pc", 16'(ir_pc), 16'd9);

      // pc wrap at 15
      redirect_valid = 1'b1; redirect_addr = 4'd15;
      step();
      redirect_valid = 1'b0;
      step();
      check_eq("t4_ir_pc15", 16'(ir_pc), 16'd15);
      check_eq("t4_addr_wrap", 16'(address), 16'd0);

      // run=0 with a stalled ir
      run = 1'b0; ir_ready = 1'b0;
      step();
      step();
      check_eq("t5_state", 16'(state), 16'(ST_STALL));
      check_eq("t5_ir_pc", 16'(ir_pc), 16'd15);
      check_eq("t5_valid", 16'(ir_valid), 16'h1);
      ir_ready = 1'b1;
      step();
      check_eq("t5_drop", 16'(ir_valid), 16'h0);
      check_eq("t5_idle", 16'(state), 16'(ST_IDLE));
      check_eq("t5_addr", 16'(address), 16'd0);

      // Reset mid-stream
      run = 1'b1;
      step();
      step();
      step();
      rst_n = 1'b0;
      step();
      check_eq("t6_pc", 16'(address), 16'd0);
      check_eq("t6_ir", ir, 16'h0000);
      check_eq("t6_valid", 16'(ir_valid), 16'h0);
      check_eq("t6_cnt", 16'(issue_count), 16'd0);
      check_eq("t6_state", 16'(state), 16'(ST_IDLE));
      rst_n = 1'b1;
      step();
      step();
      check_eq("t6_ir_first", ir, 16'h1202);
      check_eq("t6_ir_pc_first", 16'(ir_pc), 16'd0);

      // issue_count wrap over 256 issues with a JMP-free program
      for (int i = 0; i < 16; i++) rom[i] = 16'h0001 + 16'(i);
      do_reset();
      run = 1'b1; ir_ready = 1'b1;
      step();
      for (int i = 0; i < 255; i++) step();
      check_eq("t7_cnt255", 16'(issue_count), 16'd255);
      step();
      check_eq("t7_cnt_wrap", 16'(issue_count), 16'd0);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) randomize_rom();
         rst_n          = ($urandom_range(0, 99) != 0);
         run            = ($urandom_range(0, 7) != 0);
         ir_ready       = ($urandom_range(0, 2) != 0);
         redirect_valid = ($urandom_range(0, 19) == 0);
         redirect_addr  = 4'($urandom_range(0, 15));
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
